// File: rtl/imm_decode_pipe.sv
// LEGv8 immediate extractor: combinational decode, registered output stage, one-entry skid buffer.
// Optional build macro IMM_BYTEOFF_EN scales CB and B immediates to byte offsets.
module imm_decode_pipe #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_imm,
  output logic [2:0]   out_fmt
);
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_D    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_CB   = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_IW   = 3'd5;

  logic [63:0]  wide_imm;
  logic [2:0]   dec_fmt;
  logic [N-1:0] dec_imm;

  logic         out_valid_reg;
  logic [N-1:0] out_imm_reg;
  logic [2:0]   out_fmt_reg;
  logic         skid_valid_reg;
  logic [N-1:0] skid_imm_reg;
  logic [2:0]   skid_fmt_reg;

  logic accept;
  logic consume;
  logic unused_low_bits;

  assign unused_low_bits = ^in_instr[4:0];

  // Everything is built at 64 bits and truncated once, so sign extension reaches bit N-1.
  always_comb begin
    wide_imm = '0;
    dec_fmt  = FMT_NONE;
    if (in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000) begin
      wide_imm = {{55{in_instr[20]}}, in_instr[20:12]};
      dec_fmt  = FMT_D;
    end else if (in_instr[31:22] == 10'b1001000100 || in_instr[31:22] == 10'b1101000100) begin
      wide_imm = {52'd0, in_instr[21:10]};
      dec_fmt  = FMT_I;
    end else if (in_instr[31:24] == 8'b10110100 || in_instr[31:24] == 8'b10110101 ||
                 in_instr[31:24] == 8'b01010100) begin
      wide_imm = {{45{in_instr[23]}}, in_instr[23:5]};
      dec_fmt  = FMT_CB;
    end else if (in_instr[31:26] == 6'b000101 || in_instr[31:26] == 6'b100101) begin
      wide_imm = {{38{in_instr[25]}}, in_instr[25:0]};
      dec_fmt  = FMT_B;
    end else if (in_instr[31:23] == 9'b110100101) begin
      wide_imm = {48'd0, in_instr[20:5]} << {in_instr[22:21], 4'b0000};
      dec_fmt  = FMT_IW;
    end
`ifdef IMM_BYTEOFF_EN
    if (dec_fmt == FMT_CB || dec_fmt == FMT_B) begin
      wide_imm = {wide_imm[61:0], 2'b00};
    end
`else
`endif
    dec_imm = wide_imm[N-1:0];
  end

  // in_ready comes straight from the skid valid flop; no path from out_ready.
  assign in_ready  = ~skid_valid_reg;
  assign accept    = in_valid & ~skid_valid_reg;
  assign consume   = out_valid_reg & out_ready;

  assign out_valid = out_valid_reg;
  assign out_imm   = out_imm_reg;
  assign out_fmt   = out_fmt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_imm_reg    <= '0;
      out_fmt_reg    <= FMT_NONE;
      skid_valid_reg <= 1'b0;
      skid_imm_reg   <= '0;
      skid_fmt_reg   <= FMT_NONE;
    end else if (!out_valid_reg || consume) begin
      // OUT is free this edge: older skid entry has priority over new input.
      if (skid_valid_reg) begin
        out_imm_reg    <= skid_imm_reg;
        out_fmt_reg    <= skid_fmt_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_imm_reg    <= dec_imm;
        out_fmt_reg    <= dec_fmt;
        out_valid_reg  <= 1'b1;
      end else begin
        out_valid_reg  <= 1'b0;
      end
    end else if (accept) begin
      skid_imm_reg   <= dec_imm;
      skid_fmt_reg   <= dec_fmt;
      skid_valid_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_decode_pipe.sv
// Self-checking bench for imm_decode_pipe: directed vector table, backpressure and reset
// sequences, and randomized traffic against an arithmetic reference model.
module tb_imm_decode_pipe;
  localparam int N = 64;
`ifdef IMM_BYTEOFF_EN
  localparam longint BYTE_MUL = 4;
`else
  localparam longint BYTE_MUL = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_imm;
  logic [2:0]   out_fmt;

  always #5 clk = ~clk;

  imm_decode_pipe #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt)
  );

  typedef struct {
    logic [N-1:0] imm;
    logic [2:0]   fmt;
  } res_t;

  typedef struct {
    string        name;
    logic [31:0]  instr;
    logic [63:0]  imm;
    logic [2:0]   fmt;
  } vec_t;

  int   compared = 0;
  int   mismatched = 0;
  int   rcv_count = 0;
  int   stall_count = 0;
  bit   mon_en = 1'b0;
  res_t exp_q[$];
  res_t sb_e;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint sext(input longint field, input int w);
    if (field >= (longint'(1) << (w - 1))) return field - (longint'(1) << w);
    return field;
  endfunction

  // Reference: value of each field taken as an integer, scaled arithmetically.
  function automatic res_t model(input logic [31:0] a);
    res_t   r;
    longint v;
    logic [2:0] f;
    v = 0;
    f = 3'd0;
    if (a[31:21] inside {11'b11111000010, 11'b11111000000}) begin
      f = 3'd1; v = sext(longint'(a[20:12]), 9);
    end else if (a[31:22] inside {10'b1001000100, 10'b1101000100}) begin
      f = 3'd2; v = longint'(a[21:10]);
    end else if (a[31:24] inside {8'b10110100, 8'b10110101, 8'b01010100}) begin
      f = 3'd3; v = sext(longint'(a[23:5]), 19) * BYTE_MUL;
    end else if (a[31:26] inside {6'b000101, 6'b100101}) begin
      f = 3'd4; v = sext(longint'(a[25:0]), 26) * BYTE_MUL;
    end else if (a[31:23] == 9'b110100101) begin
      f = 3'd5; v = longint'(a[20:5]) * (longint'(1) << (16 * int'(a[22:21])));
    end
    r.fmt = f;
    r.imm = v[N-1:0];
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000;
      1: r[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
      2: case ($urandom_range(0, 2))
           0: r[31:24] = 8'b10110100;
           1: r[31:24] = 8'b10110101;
           default: r[31:24] = 8'b01010100;
         endcase
      3: r[31:26] = ($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101;
      4: r[31:23] = 9'b110100101;
      default: ;
    endcase
    return r;
  endfunction

  // Scoreboard: pops on every consume, pushes the model result on every accept.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL sb_unexpected: got output %h/%0d expected none", out_imm, out_fmt);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_imm", 64'(out_imm), 64'(sb_e.imm));
          check("sb_fmt", 64'(out_fmt), 64'(sb_e.fmt));
          rcv_count++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_instr));
      if (in_valid && !in_ready) stall_count++;
    end
  end

  task automatic drain(input string name);
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge clk); #1;
      budget++;
    end
    @(posedge clk); #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"ldur_neg",   32'hF85F8041, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1};
    vecs[1]  = '{"stur_pos",   32'hF80FF000, 64'h0000_0000_0000_00FF, 3'd1};
    vecs[2]  = '{"addi_max",   32'h913FFC00, 64'h0000_0000_0000_0FFF, 3'd2};
    vecs[3]  = '{"subi_one",   32'hD1000400, 64'h0000_0000_0000_0001, 3'd2};
    vecs[4]  = '{"cbz_neg1",   32'hB4FFFFE0, (BYTE_MUL == 4) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'hFFFF_FFFF_FFFF_FFFF, 3'd3};
    vecs[5]  = '{"cbnz_max",   32'hB57FFFE0, (BYTE_MUL == 4) ? 64'h0000_0000_000F_FFFC : 64'h0000_0000_0003_FFFF, 3'd3};
    vecs[6]  = '{"bcond_2",    32'h54000040, (BYTE_MUL == 4) ? 64'h0000_0000_0000_0008 : 64'h0000_0000_0000_0002, 3'd3};
    vecs[7]  = '{"b_neg1",     32'h17FFFFFF, (BYTE_MUL == 4) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'hFFFF_FFFF_FFFF_FFFF, 3'd4};
    vecs[8]  = '{"bl_one",     32'h94000001, (BYTE_MUL == 4) ? 64'h0000_0000_0000_0004 : 64'h0000_0000_0000_0001, 3'd4};
    vecs[9]  = '{"movz_hw2",   32'hD2C24680, 64'h0000_1234_0000_0000, 3'd5};
    vecs[10] = '{"movz_hw3",   32'hD2FFFFE0, 64'hFFFF_0000_0000_0000, 3'd5};
    vecs[11] = '{"zero_word",  32'h00000000, 64'h0000_0000_0000_0000, 3'd0};
    vecs[12] = '{"add_reg",    32'h8B020020, 64'h0000_0000_0000_0000, 3'd0};

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_imm",   64'(out_imm),   64'd0);
    check("rst_out_fmt",   64'(out_fmt),   64'd0);
    reset = 1'b0;

    // Directed vectors, back to back, result checked one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      @(posedge clk); #1;
      check({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
      check({vecs[i].name, "_imm"},   64'(out_imm),   vecs[i].imm);
      check({vecs[i].name, "_fmt"},   64'(out_fmt),   64'(vecs[i].fmt));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: three words offered while the consumer is stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = vecs[0].instr;
    @(posedge clk); #1;
    check("bp_first_valid", 64'(out_valid), 64'd1);
    check("bp_first_ready", 64'(in_ready), 64'd1);
    in_instr = vecs[2].instr;
    @(posedge clk); #1;
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_hold_imm", 64'(out_imm), vecs[0].imm);
    in_instr = vecs[9].instr;
    repeat (2) @(posedge clk);
    #1;
    check("bp_stall_ready", 64'(in_ready), 64'd0);
    check("bp_stall_imm", 64'(out_imm), vecs[0].imm);
    check("bp_stall_fmt", 64'(out_fmt), 64'(vecs[0].fmt));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_out2_imm", 64'(out_imm), vecs[2].imm);
    check("bp_out2_fmt", 64'(out_fmt), 64'(vecs[2].fmt));
    check("bp_out2_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_out3_valid", 64'(out_valid), 64'd1);
    check("bp_out3_imm", 64'(out_imm), vecs[9].imm);
    check("bp_out3_fmt", 64'(out_fmt), 64'(vecs[9].fmt));
    @(posedge clk); #1;
    check("bp_empty_valid", 64'(out_valid), 64'd0);

    // Full-rate streaming: 100 random words, no stalls, all out by the next cycle.
    mon_en = 1'b1;
    rcv_count = 0;
    stall_count = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_instr = rand_instr();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("stream_count", 64'(rcv_count), 64'd100);
    check("stream_stalls", 64'(stall_count), 64'd0);
    drain("stream_drain");

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_instr  = rand_instr();
      @(posedge clk); #1;
    end
    drain("random_drain");

    // Reset while FULL; the reset cycle offers both accept and consume.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = vecs[4].instr;
    @(posedge clk); #1;
    in_instr = vecs[7].instr;
    @(posedge clk); #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1; out_ready = 1'b1; in_instr = vecs[9].instr;
    @(posedge clk); #1;
    check("rstfull_out_valid", 64'(out_valid), 64'd0);
    check("rstfull_in_ready",  64'(in_ready),  64'd1);
    check("rstfull_out_fmt",   64'(out_fmt),   64'd0);
    check("rstfull_out_imm",   64'(out_imm),   64'd0);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(out_valid), 64'd0);

    rcv_count = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      out_ready = ($urandom_range(0, 1) != 0);
      in_instr  = rand_instr();
      @(posedge clk); #1;
    end
    drain("post_rst_drain");
    if (rcv_count == 0) begin
      compared++;
      mismatched++;
      $display("FAIL post_rst_traffic: got %0d outputs expected some", rcv_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
